// File: rtl/noc_pkt_sink_checker.sv
// Packet sink for a mesh router local port: consumes flits with optional LFSR
// backpressure and checks header, length and per-source sequence numbers.
module noc_pkt_sink_checker #(
    parameter int         DATA_WIDTH = 32,
    parameter int         X_CUR      = 2,
    parameter int         Y_CUR      = 2,
    parameter int         MESH_X     = 4,
    parameter int         MESH_Y     = 4,
    parameter int         PKT_FLITS  = 4,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Valid_in,
    input  logic [DATA_WIDTH-1:0] Data_in,
    input  logic                  Last_in,
    output logic                  Ready_in,
    input  logic                  stall_en,
    output logic [9:0]            receive_cnt,
    output logic [7:0]            err_cnt,
    output logic                  error_flag,
    output logic [2:0]            err_code,
    output logic                  pkt_done,
    output logic                  pkt_ok
);
    localparam int NSRC = MESH_X * MESH_Y;
    localparam int IDXW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam logic [3:0] PF = 4'(PKT_FLITS);

    localparam logic [2:0] E_NONE  = 3'd0;
    localparam logic [2:0] E_DEST  = 3'd1;
    localparam logic [2:0] E_SRC   = 3'd2;
    localparam logic [2:0] E_HDR   = 3'd3;
    localparam logic [2:0] E_SHORT = 3'd4;
    localparam logic [2:0] E_LONG  = 3'd5;
    localparam logic [2:0] E_SEQ   = 3'd6;

    typedef enum logic [1:0] {IDLE, BODY, DROP} state_t;

    state_t          state, state_next;
    logic [7:0]      lfsr, lfsr_next;
    logic [3:0]      count, count_next, cnt_inc;
    logic [27:0]     hdr, hdr_next, in_hdr, cur_hdr;
    logic [2:0]      pkt_code, pkt_code_next, flit_code, base_code, tot_code;
    logic            accept, finish, len_ok, src_ok, seq_chk;
    logic [IDXW-1:0] src_idx;
    logic [3:0]      seq_in, seq_exp;
    logic [3:0]      seq_tab [NSRC];

    always_comb begin
        accept    = Valid_in & Ready_in;
        lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        in_hdr    = Data_in[DATA_WIDTH-1 -: 28];
        // The source of a packet is always taken from its first flit.
        cur_hdr   = (state == IDLE) ? in_hdr : hdr;
        src_ok    = ({1'b0, cur_hdr[13:7]} < 8'(MESH_X)) && ({1'b0, cur_hdr[6:0]} < 8'(MESH_Y));
        src_idx   = IDXW'(cur_hdr[6:0] * 7'(MESH_X) + cur_hdr[13:7]);
        seq_in    = Data_in[3:0];
        seq_exp   = seq_tab[src_idx];
        cnt_inc   = count + 4'd1;

        state_next = state;
        count_next = count;
        hdr_next   = hdr;
        finish     = 1'b0;
        len_ok     = 1'b0;
        flit_code  = E_NONE;

        if (accept) begin
            unique case (state)
                IDLE: begin
                    hdr_next   = in_hdr;
                    count_next = 4'd1;
                    if (in_hdr[27:21] != 7'(X_CUR) || in_hdr[20:14] != 7'(Y_CUR))
                        flit_code = E_DEST;
                    else if (!src_ok)
                        flit_code = E_SRC;
                    if (Last_in) begin
                        finish = 1'b1;
                        len_ok = (PF == 4'd1);
                        if (!len_ok && flit_code == E_NONE) flit_code = E_SHORT;
                    end else if (PF == 4'd1) begin
                        if (flit_code == E_NONE) flit_code = E_LONG;
                        state_next = DROP;
                    end else begin
                        state_next = BODY;
                    end
                end
                BODY: begin
                    count_next = cnt_inc;
                    if (in_hdr != hdr) flit_code = E_HDR;
                    if (Last_in) begin
                        finish     = 1'b1;
                        state_next = IDLE;
                        len_ok     = (cnt_inc == PF);
                        if (!len_ok && flit_code == E_NONE) flit_code = E_SHORT;
                    end else if (cnt_inc == PF) begin
                        if (flit_code == E_NONE) flit_code = E_LONG;
                        state_next = DROP;
                    end
                end
                DROP: begin
                    if (Last_in) begin
                        finish     = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        seq_chk = finish & len_ok & src_ok;
        if (seq_chk && seq_in != seq_exp && flit_code == E_NONE) flit_code = E_SEQ;

        // An earlier flit's error always shadows anything found later in the packet.
        base_code     = (state == IDLE) ? E_NONE : pkt_code;
        tot_code      = (base_code != E_NONE) ? base_code : flit_code;
        pkt_code_next = accept ? tot_code : pkt_code;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr        <= LFSR_SEED;
            Ready_in    <= 1'b0;
            count       <= 4'd0;
            hdr         <= 28'd0;
            pkt_code    <= E_NONE;
            receive_cnt <= 10'd0;
            err_cnt     <= 8'd0;
            error_flag  <= 1'b0;
            err_code    <= E_NONE;
            pkt_done    <= 1'b0;
            pkt_ok      <= 1'b0;
            for (int i = 0; i < NSRC; i++) seq_tab[i] <= 4'd1;
        end else begin
            lfsr     <= lfsr_next;
            Ready_in <= stall_en ? lfsr_next[0] : 1'b1;
            count    <= count_next;
            hdr      <= hdr_next;
            pkt_code <= pkt_code_next;
            pkt_done <= finish;
            pkt_ok   <= finish && (tot_code == E_NONE);
            if (finish) begin
                receive_cnt <= receive_cnt + 10'd1;
                if (tot_code != E_NONE) begin
                    if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                    if (!error_flag) begin
                        error_flag <= 1'b1;
                        err_code   <= tot_code;
                    end
                end
            end
            // On a match seq equals the expected value, so seq+1 covers both match and resync.
            if (seq_chk) seq_tab[src_idx] <= seq_in + 4'd1;
        end
    end
endmodule

// File: doc/noc_pkt_sink_checker.md
Name: noc_pkt_sink_checker

Overview:
- Endpoint receiver/scoreboard attached to a router local output port, mirroring the traffic-generating IP that injects packets.
- Consumes flits on the valid/ready/last interface, with optional pseudo-random backpressure.
- Checks every packet's header, length and per-source sequence number, and exposes counters plus a sticky error status for the testbench and FPGA debug.

Parameters:
- DATA_WIDTH, 32, flit width; must be at least 32.
- X_CUR, 2, X coordinate of this node.
- Y_CUR, 2, Y coordinate of this node.
- MESH_X, 4, number of mesh columns; legal source X is 0..MESH_X-1.
- MESH_Y, 4, number of mesh rows; legal source Y is 0..MESH_Y-1.
- PKT_FLITS, 4, required flits per packet (1..15).
- LFSR_SEED, 8'hA5, nonzero backpressure LFSR seed.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high; one clock domain
- Valid_in  in  1  flit valid
- Data_in  in  DATA_WIDTH  flit data
- Last_in  in  1  last flit of packet
- Ready_in  out  1  sink ready (registered)
- stall_en  in  1  1 = random backpressure, 0 = always ready
- receive_cnt  out  10  packets completed, wraps 1023->0
- err_cnt  out  8  packets with an error, saturates at 255
- error_flag  out  1  sticky, set on first error
- err_code  out  3  code of the first error since reset
- pkt_done  out  1  one-cycle pulse per completed packet
- pkt_ok  out  1  valid with pkt_done; 1 = packet clean

Behaviour:
- Flit field map:
  - dest X = Data_in[W-1 -: 7]
  - dest Y = [W-8 -: 7]
  - src X = [W-15 -: 7]
  - src Y = [W-22 -: 7]
  - seq = [3:0], checked on the last flit only.
  - "Header" means bits [W-1 -: 28].
- Accept: a flit is accepted only when Valid_in & Ready_in. Valid_in without Ready_in has no effect.
- Ready_in:
  - Registered: next value = stall_en ? lfsr_next[0] : 1.
  - LFSR: 8-bit Fibonacci, taps 8,6,5,4, steps every cycle.
  - Reset values: Ready_in=0, lfsr=LFSR_SEED.
- Reset values: all outputs 0, FSM=IDLE, flit counter 0, all expected-seq entries = 1 (the first packet from each source carries seq 1).
- FSM states: IDLE, BODY, DROP.
- IDLE, on accept:
  - Latch header; flit count = 1.
  - Check dest == (X_CUR, Y_CUR), else DEST error (code 1).
  - Check src in range, else SRC error (code 2).
  - If Last_in: finish the packet (this covers PKT_FLITS=1); otherwise go to BODY.
- BODY, on accept:
  - Header must equal the latched header, else HDR error (code 3).
  - Last_in with count+1 < PKT_FLITS: SHORT error (code 4); finish; go to IDLE.
  - count+1 == PKT_FLITS and Last_in: finish; go to IDLE.
  - count+1 == PKT_FLITS and !Last_in: LONG error (code 5); go to DROP.
- DROP: accept and discard flits until Last_in; then finish and go to IDLE.
- Seq check, at finish only and only when length is correct and src is in range:
  - exp = table[src].
  - seq == exp: table[src] <= exp+1 (4-bit wrap 15->0).
  - Mismatch: SEQ error (code 6); resync table[src] <= seq+1.
- Error recording:
  - At most one error is recorded per packet: the first detected in flit order. At the same flit, the lower code wins.
  - err_cnt increments at most once per packet.
  - error_flag and err_code are written only on the first error after reset and never cleared except by reset.
- Finish, the cycle after the last accepted flit:
  - pkt_done=1.
  - pkt_ok = no error in this packet.
  - receive_cnt increments whether or not the packet had an error.
- Reset asserted mid-packet: the partial packet is discarded; counters and the table return to reset values; the next accepted flit is treated as a header.

Test Plan:
- stall_en=0; 3 clean 4-flit packets from (1,0) to (2,2) with last-flit seq 1,2,3 -> Ready_in=1 from cycle 1; three pkt_done pulses with pkt_ok=1; receive_cnt=3; error_flag=0.
- Packet with dest (3,2) -> pkt_ok=0, err_code=1, err_cnt=1. A following clean packet gives pkt_ok=1 and err_code stays 1.
- Last_in on flit 2 of 4, then a normal packet -> code 4 on the first; the second is accepted cleanly (FSM back in IDLE).
- 6 flits with Last_in on flit 6 -> code 5 at flit 4; flits 5-6 consumed in DROP; exactly one pkt_done; err_cnt +1.
- Source (0,1) sends seq 1 then 3 then 4 -> second packet gives SEQ error (code 6); third packet is clean after resync. Source (1,1) interleaved with seq 1 is clean, confirming per-source tracking.
- stall_en=1 for 500 cycles of random traffic -> Ready_in follows the LFSR; no flit is lost or duplicated; receive_cnt equals packets sent. Reset asserted mid-packet -> all counters read 0 next cycle.
